// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: the ALU has fixed priority over a buffered load/store FIFO, and writes to x0 are dropped.
// Define WB_SCOREBOARD_EN to build the pending-load busy mask; otherwise busy is tied to zero.
module writeback_arbiter #(
  parameter int MEM_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:0] busy,
  output logic        write_enable,
  output logic [4:0]  rd,
  output logic [31:0] result
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // Handshake: a mem entry transfers on any cycle where mem_valid && mem_ready.
  // mem_ready depends only on registered occupancy, never on this cycle's pop.
  logic [4:0]    fifo_rd_q   [MEM_DEPTH];
  logic [31:0]   fifo_data_q [MEM_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          write_enable_q, write_enable_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   result_q, result_d;
  logic          alu_win, push, pop;

  assign mem_ready = (count_q != (AW+1)'(MEM_DEPTH));
  assign alu_win   = alu_valid && (alu_rd != 5'd0);
  assign push      = mem_valid && mem_ready && (mem_rd != 5'd0);

  always_comb begin
    write_enable_d = 1'b0;
    rd_d           = rd_q;
    result_d       = result_q;
    pop            = 1'b0;
    if (alu_win) begin
      write_enable_d = 1'b1;
      rd_d           = alu_rd;
      result_d       = alu_result;
    end else if (count_q != '0) begin
      pop            = 1'b1;
      write_enable_d = 1'b1;
      rd_d           = fifo_rd_q[rd_ptr_q];
      result_d       = fifo_data_q[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      write_enable_q <= 1'b0;
      rd_q           <= 5'd0;
      result_q       <= 32'd0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      write_enable_q <= write_enable_d;
      rd_q           <= rd_d;
      result_q       <= result_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= mem_rd;
      fifo_data_q[wr_ptr_q] <= mem_result;
    end
  end

  assign write_enable = write_enable_q;
  assign rd           = rd_q;
  assign result       = result_q;

`ifdef WB_SCOREBOARD_EN
  logic        src_mem_q;
  logic [31:0] busy_q, busy_d;

  // Clear on the edge where the register file captures a FIFO write; a same-edge issue wins.
  always_comb begin
    busy_d = busy_q;
    if (write_enable_q && src_mem_q) busy_d[rd_q] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_mem_q <= 1'b0;
      busy_q    <= 32'd0;
    end else begin
      src_mem_q <= pop;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_rd};
  assign busy = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomised and directed bench for writeback_arbiter against a queue-based model of the port and busy mask.
module tb_writeback_arbiter;

  localparam int DEPTH = 2;
  localparam int W     = 53; // {cycle tag[15:0], rd[4:0], data[31:0]}

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_result = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_result = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] busy;
  logic        write_enable;
  logic [4:0]  rd;
  logic [31:0] result;

  writeback_arbiter #(.MEM_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_result(mem_result),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
    .write_enable(write_enable), .rd(rd), .result(result)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit running = 0;

  logic [W-1:0]  exp_q[$];
  logic [36:0]   fifo_m[$];
  logic [31:0]   busy_cur = '0;
  logic [31:0]   busy_next = '0;
  logic          last_mem = 1'b0;
  logic [4:0]    last_rd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Reference: a write decided at an edge appears one cycle later; FIFO is a plain queue.
  task automatic model_step(output logic acc);
    logic        ready_exp;
    logic        mem_src;
    logic [4:0]  mrd;
    logic [36:0] e;
    logic [31:0] nb;
    ready_exp = (fifo_m.size() < DEPTH);
    check("mem_ready", {63'd0, mem_ready}, {63'd0, ready_exp});
    mem_src = 1'b0;
    mrd = '0;
    if (alu_valid && alu_rd != 0) begin
      exp_q.push_back({16'(cyc + 1), alu_rd, alu_result});
    end else if (fifo_m.size() > 0) begin
      e = fifo_m.pop_front();
      exp_q.push_back({16'(cyc + 1), e});
      mem_src = 1'b1;
      mrd = e[36:32];
    end
    acc = mem_valid && ready_exp;
    if (acc && mem_rd != 0) fifo_m.push_back({mem_rd, mem_result});
`ifdef WB_SCOREBOARD_EN
    nb = busy_cur;
    if (last_mem) nb[last_rd] = 1'b0;
    if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
    nb[0] = 1'b0;
`else
    nb = 32'd0;
`endif
    busy_next = nb;
    last_mem = mem_src;
    last_rd = mrd;
  endtask

  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ares,
                      input logic mv, input logic [4:0] mrd_i, input logic [31:0] mres,
                      input logic iv, input logic [4:0] ird, output logic acc);
    @(posedge clock);
    cyc++;
    busy_cur = busy_next;
    #1;
    alu_valid = av; alu_rd = ard; alu_result = ares;
    mem_valid = mv; mem_rd = mrd_i; mem_result = mres;
    issue_valid = iv; issue_rd = ird;
    #1;
    model_step(acc);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, a);
  endtask

  task automatic do_reset_mid();
    #2;
    reset = 1'b1;
    #1;
    check("rst_we",     {63'd0, write_enable}, 64'd0);
    check("rst_rd",     {59'd0, rd}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_busy",   {32'd0, busy}, 64'd0);
    check("rst_ready",  {63'd0, mem_ready}, 64'd1);
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
    exp_q.delete(); fifo_m.delete();
    busy_cur = '0; busy_next = '0; last_mem = 1'b0; last_rd = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Monitor: every cycle either the next expected write is on the port or nothing is.
  always @(negedge clock) begin
    if (running && !reset) begin
      logic [W-1:0] e;
      if (write_enable) begin
        if (exp_q.size() == 0) begin
          check("spurious_write", {27'd0, 16'(cyc), rd, result[15:0]}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("port_write", {11'd0, 16'(cyc), rd, result}, {11'd0, e});
        end
      end else if (exp_q.size() > 0 && exp_q[0][52:37] <= 16'(cyc)) begin
        e = exp_q.pop_front();
        check("missing_write", 64'd0, {11'd0, e});
      end else begin
        check("port_idle", {63'd0, write_enable}, 64'd0);
      end
      check("busy", {32'd0, busy}, {32'd0, busy_cur});
    end
  end

  logic        a;
  logic        pend_v;
  logic [4:0]  pend_rd;
  logic [31:0] pend_res;

  initial begin
    reset = 1'b1;
    #12;
    check("init_we",    {63'd0, write_enable}, 64'd0);
    check("init_rd",    {59'd0, rd}, 64'd0);
    check("init_result",{32'd0, result}, 64'd0);
    check("init_busy",  {32'd0, busy}, 64'd0);
    #10 reset = 1'b0;
    running = 1;

    // ALU only, then ALU to x0.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 0, 0, 0, 0, a);
    step(1, 0, 32'h12345678, 0, 0, 0, 0, 0, a);
    idle(2);

    // Contention: ALU writes 3 cycles while two mem entries are pushed.
    step(1, 1, 32'hA1, 1, 7, 32'h11, 0, 0, a);
    step(1, 2, 32'hA2, 1, 8, 32'h22, 0, 0, a);
    step(1, 3, 32'hA3, 0, 0, 0, 0, 0, a);
    idle(4);

    // Full + simultaneous offer: entry 3 must wait a cycle.
    step(1, 4, 32'hB1, 1, 10, 32'h100, 0, 0, a);
    step(1, 4, 32'hB2, 1, 11, 32'h200, 0, 0, a);
    a = 0;
    for (int i = 0; i < 5 && !a; i++) step(0, 0, 0, 1, 12, 32'h300, 0, 0, a);
    check("full_push_accepted", {63'd0, a}, 64'd1);
    idle(3);

    // Mem to x0 is accepted and dropped.
    step(0, 0, 0, 1, 0, 32'h555, 0, 0, a);
    check("x0_mem_accepted", {63'd0, a}, 64'd1);
    idle(2);

    // Scoreboard: set, clear by mem write, set colliding with clear, issue to x0.
    step(0, 0, 0, 0, 0, 0, 1, 9, a);
    step(0, 0, 0, 1, 9, 32'h99, 0, 0, a);
    step(0, 0, 0, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 0, 0, 0, 1, 9, a);
    idle(2);
    step(0, 0, 0, 1, 9, 32'h98, 0, 0, a);
    step(0, 0, 0, 0, 0, 0, 1, 0, a);
    step(1, 9, 32'h77, 0, 0, 0, 0, 0, a);
    idle(3);
    for (int r = 0; r < 32; r++) step(0, 0, 0, 0, 0, 0, 1, 5'(r), a);
    for (int r = 1; r < 32; r++) step(0, 0, 0, 1, 5'(r), 32'(r * 3), 0, 0, a);
    idle(4);

    // Random traffic with held mem offers.
    pend_v = 0; pend_rd = 0; pend_res = 0;
    for (int i = 0; i < 600; i++) begin
      if (!pend_v && $urandom_range(0, 2) != 0) begin
        pend_v = 1;
        pend_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        pend_res = $urandom;
      end
      step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
           pend_v, pend_rd, pend_res,
           $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), a);
      if (a) pend_v = 0;
    end
    idle(4);

    // Reset mid-stream with two FIFO entries and a write on the port.
    step(1, 6, 32'hC1, 1, 13, 32'h400, 0, 0, a);
    step(1, 6, 32'hC2, 1, 14, 32'h500, 1, 13, a);
    step(1, 6, 32'hC3, 0, 0, 0, 0, 0, a);
    do_reset_mid();
    idle(6);

    check("drain_empty", 64'(exp_q.size()), 64'd0);
    running = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
